serial_deserializer: RTL



---
 rtl/serial_deserializer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/serial_deserializer.sv
// Sync-hunting serial receiver: finds SYNC_WORD, assembles WIDTH bits, offers them on valid/ready.
// Optional even-parity bit after the data when DESER_PARITY_EN is defined.
module serial_deserializer #(
   parameter int unsigned       WIDTH     = 32,
   parameter int unsigned       SYNC_W    = 8,
   parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clken,
   input  logic             SI,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   output logic             locked,
   output logic             overrun
`ifdef DESER_PARITY_EN
   ,
   output logic             parity_err
`endif
);

   localparam int unsigned HcW = $clog2(SYNC_W + 1);
   localparam int unsigned BcW = $clog2(WIDTH);
   localparam logic [HcW-1:0] HuntSat = HcW'(SYNC_W);
   localparam logic [HcW-1:0] HuntMin = HcW'(SYNC_W - 1);
   localparam logic [BcW-1:0] LastBit = BcW'(WIDTH - 1);

`ifdef DESER_PARITY_EN
   typedef enum logic [1:0] {StHunt, StData, StPar} state_e;
`else
   typedef enum logic [1:0] {StHunt, StData} state_e;
`endif

   state_e             state_q;
   logic [SYNC_W-2:0]  win_q;
   logic [HcW-1:0]     hunt_cnt_q;
   logic [BcW-1:0]     bit_cnt_q;
   logic [WIDTH-2:0]   sh_q;
   logic [WIDTH-1:0]   m_data_q;
   logic               m_valid_q;
   logic               overrun_q;
`ifdef DESER_PARITY_EN
   logic [WIDTH-1:0]   pend_q;
   logic               parity_err_q;
`endif

   logic [SYNC_W-1:0]  win_next;
   logic [WIDTH-1:0]   word_next;
   logic               can_load;
   logic               sync_hit;

   // Only SYNC_W-1 history bits are kept; the incoming bit completes the window.
   assign win_next  = {win_q, SI};
   assign word_next = {sh_q, SI};
   assign can_load  = !m_valid_q || m_ready;
   assign sync_hit  = (hunt_cnt_q >= HuntMin) && (win_next == SYNC_WORD);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StHunt;
         win_q      <= '0;
         hunt_cnt_q <= '0;
         bit_cnt_q  <= '0;
         sh_q       <= '0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         overrun_q  <= 1'b0;
`ifdef DESER_PARITY_EN
         pend_q       <= '0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         if (m_valid_q && m_ready) m_valid_q <= 1'b0;
`ifdef DESER_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         if (clken) begin
            unique case (state_q)
               StHunt: begin
                  win_q <= win_next[SYNC_W-2:0];
                  if (hunt_cnt_q != HuntSat) hunt_cnt_q <= hunt_cnt_q + 1'b1;
                  if (sync_hit) begin
                     state_q   <= StData;
                     bit_cnt_q <= '0;
                  end
               end
               StData: begin
                  sh_q      <= word_next[WIDTH-2:0];
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == LastBit) begin
`ifdef DESER_PARITY_EN
                     pend_q  <= word_next;
                     state_q <= StPar;
`else
                     state_q    <= StHunt;
                     win_q      <= '0;
                     hunt_cnt_q <= '0;
                     if (can_load) begin
                        m_data_q  <= word_next;
                        m_valid_q <= 1'b1;
                     end else begin
                        overrun_q <= 1'b1;
                     end
`endif
                  end
               end
`ifdef DESER_PARITY_EN
               StPar: begin
                  state_q    <= StHunt;
                  win_q      <= '0;
                  hunt_cnt_q <= '0;
                  // Bad parity drops the word without touching the holding register.
                  if (^{pend_q, SI}) begin
                     parity_err_q <= 1'b1;
                  end else if (can_load) begin
                     m_data_q  <= pend_q;
                     m_valid_q <= 1'b1;
                  end else begin
                     overrun_q <= 1'b1;
                  end
               end
`endif
               default: state_q <= StHunt;
            endcase
         end
      end
   end

   assign m_data  = m_data_q;
   assign m_valid = m_valid_q;
   assign locked  = (state_q != StHunt);
   assign overrun = overrun_q;
`ifdef DESER_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule
